// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, constants and the prefetch entry type for the fetch unit
package fetch_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory, redirect and decode-handshake signals of the fetch unit
//   master (fetch_unit): drives imem_addr, if_valid, if_instr, if_pc
//   slave  (memory/decode/execute side): drives imem_rdata, redirect_valid, redirect_pc, if_ready
interface fetch_unit_if;
    import fetch_pkg::*;
    logic [XLEN-1:0] imem_addr;
    logic [ILEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            if_valid;
    logic            if_ready;
    logic [ILEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    modport master (
        output imem_addr, if_valid, if_instr, if_pc,
        input  imem_rdata, redirect_valid, redirect_pc, if_ready
    );
    modport slave (
        input  imem_addr, if_valid, if_instr, if_pc,
        output imem_rdata, redirect_valid, redirect_pc, if_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO of fetch_entry_t entries
//   clk, rst : clock, synchronous active-high reset (clears storage and pointers)
//   push/din : write din at the tail
//   pop      : retire the head
//   flush    : empty the FIFO; wins over push and pop
//   full, empty, head : status and head entry (head read straight from storage, never X)
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);
    localparam int AW = $clog2(DEPTH);
    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign head    = mem[rptr];
    assign do_push = push & !flush;
    assign do_pop  = pop & !empty & !flush;
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing, push/redirect arbitration and prefetch FIFO feeding decode
//   clk, rst    : clock, synchronous active-high reset
//   bus         : fetch_unit_if.master (imem address/data, redirect, decode valid/ready)
//   fetch_count : pop counter, present only when FETCH_PERF_CNT_EN is defined
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst,
    fetch_unit_if.master     bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      fetch_count
`endif
);
    logic [XLEN-1:0] pc;
    logic            pop, push, full, empty;
    fetch_entry_t    head;
    assign pop           = bus.if_valid & bus.if_ready;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a fetch.
    assign push          = !bus.redirect_valid & (!full | pop);
    assign bus.imem_addr = pc;
    assign bus.if_valid  = !empty;
    assign bus.if_instr  = head.instr;
    assign bus.if_pc     = head.pc;
    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .din   ('{pc: pc, instr: bus.imem_rdata}),
        .full  (full),
        .empty (empty),
        .head  (head)
    );
    always_ff @(posedge clk) begin
        if (rst) pc <= RESET_PC;
        else if (bus.redirect_valid) pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
        else if (push) pc <= pc + PC_STEP;
    end
`ifdef FETCH_PERF_CNT_EN
    // Counts every handshake, including one whose entry a redirect discards.
    always_ff @(posedge clk) begin
        if (rst) fetch_count <= '0;
        else if (pop) fetch_count <= fetch_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    int n_cmp = 0;
    int n_err = 0;
    fetch_unit_if bus ();
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif
    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count (fetch_count)
`endif
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0) return 32'h0062E233;
        if (a == 32'h4) return 32'h00B62423;
        return 32'hC000_0000 ^ a;
    endfunction
    assign bus.imem_rdata = memf(bus.imem_addr);
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic head_is(input string tag, input logic [31:0] p);
        check({tag, " valid"}, 32'(bus.if_valid), 32'd1);
        check({tag, " pc"}, bus.if_pc, p);
        check({tag, " instr"}, bus.if_instr, memf(p));
    endtask
    task automatic redirect(input logic [31:0] t);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = t;
        tick();
        bus.redirect_valid = 1'b0;
    endtask
    initial begin
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.if_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset valid", 32'(bus.if_valid), 32'd0);
        check("reset addr", bus.imem_addr, 32'h0);
        check("reset pc", bus.if_pc, 32'h0);
        // streaming: head appears one cycle after the first fetch, then 1 per cycle
        bus.if_ready = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            head_is($sformatf("stream%0d", k), 32'(4 * k));
            tick();
        end
        // backpressure
        bus.if_ready = 1'b0;
        redirect(32'h0);
        check("bp redir valid", 32'(bus.if_valid), 32'd0);
        check("bp redir addr", bus.imem_addr, 32'h0);
        tick();
        check("bp first fetch", bus.imem_addr, 32'h4);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("bp freeze%0d", k), bus.imem_addr, 32'h8);
        end
        head_is("bp held", 32'h0);
        bus.if_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            head_is($sformatf("bp release%0d", k), 32'(4 * k));
        end
        // redirect while full, with a pop in the redirect cycle
        bus.if_ready = 1'b0;
        tick();
        tick();
        bus.if_ready = 1'b1;
        redirect(32'h0000_0103);
        check("full redir valid", 32'(bus.if_valid), 32'd0);
        check("full redir addr", bus.imem_addr, 32'h100);
        tick();
        head_is("full redir head", 32'h100);
        // back-to-back redirects: only the last target streams
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h40;
        tick();
        check("b2b mid valid", 32'(bus.if_valid), 32'd0);
        check("b2b mid addr", bus.imem_addr, 32'h40);
        redirect(32'h80);
        check("b2b valid", 32'(bus.if_valid), 32'd0);
        check("b2b addr", bus.imem_addr, 32'h80);
        for (int k = 0; k < 4; k++) begin
            tick();
            head_is($sformatf("b2b stream%0d", k), 32'h80 + 32'(4 * k));
        end
        // PC wrap
        redirect(32'hFFFF_FFFC);
        tick();
        head_is("wrap top", 32'hFFFF_FFFC);
        tick();
        head_is("wrap zero", 32'h0);
        // reset overrides a simultaneous redirect and handshake
        rst = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h200;
        tick();
        bus.redirect_valid = 1'b0;
        check("rst over redir addr", bus.imem_addr, 32'h0);
        check("rst over redir valid", 32'(bus.if_valid), 32'd0);
        check("rst head pc", bus.if_pc, 32'h0);
        check("rst head instr", bus.if_instr, 32'h0);
        rst = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        check("cnt reset", fetch_count, 32'd0);
        bus.if_ready = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) tick();
        bus.if_ready = 1'b0;
        check("cnt ten", fetch_count, 32'd10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("cnt cleared", fetch_count, 32'd0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch initiator for the pipelined RISC-V core. Drives word addresses into the combinational instruction memory, captures the returned instruction words with their PCs into a small prefetch FIFO, and presents them to decode over a valid/ready handshake. Decode or execute can redirect it for branches, jumps and flushes.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `DEPTH`, default 2: prefetch FIFO entries; power of two, ≥2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `imem_addr` output 32: fetch address to instruction memory; always equals internal `pc`.
- `imem_rdata` input 32: instruction word, combinational from `imem_addr` in the same cycle.
- `redirect_valid` input 1: load new PC and flush.
- `redirect_pc` input 32: target PC; bits [1:0] ignored (treated as 0).
- `if_valid` output 1: FIFO head holds a valid instruction.
- `if_ready` input 1: decode accepts head this cycle.
- `if_instr` output 32: head instruction word.
- `if_pc` output 32: head instruction PC.
- `fetch_count` output 32: present only with `FETCH_PERF_CNT_EN`.

## Operation
- State: `pc` register, FIFO of {pc, instr} entries, occupancy `count` (0..DEPTH).
- `pop` = `if_valid & if_ready`. `push` = `!redirect_valid & (count < DEPTH | pop)`.
- On push: FIFO writes {`pc`, `imem_rdata`}; `pc` <= `pc` + 4, 32-bit wrap (32'hFFFF_FFFC -> 0).
- No push: `pc` holds; `imem_addr` stays stable.
- Full and pop in the same cycle: push and pop both happen; `count` stays DEPTH.
- Empty and push: the entry becomes visible next cycle. There is no same-cycle bypass.
- Redirect has priority over everything:
  - FIFO is flushed (`count` <= 0).
  - `pc` <= {`redirect_pc`[31:2], 2'b00}.
  - No push that cycle.
  - A pop that cycle still counts as a handshake, but its entry is discarded along with the rest.
- Back-to-back redirects: the last one wins. No push while `redirect_valid` stays high.
- `if_valid` = (`count` != 0). `if_instr`/`if_pc` are don't-care while `if_valid` is 0, but are driven from the head entry (no X).
- Decode must hold `if_ready` independent of `if_instr`. `if_valid` never drops without a pop or a redirect.

## Timing
- Reset (cycle after `rst` is sampled high):
  - `pc` = `RESET_PC`, `imem_addr` = `RESET_PC`.
  - `count` = 0, `if_valid` = 0.
  - FIFO storage zeroed, `fetch_count` = 0.
- Reset during an operation overrides redirect and handshake in that cycle.
- Fetch-to-decode latency: 1 cycle. An address presented in cycle N appears at the FIFO head in cycle N+1, provided it is not blocked by older entries.
- Redirect penalty: redirect in cycle N; target fetched in N+1; `if_valid` for the target in N+2.
- Sustained throughput: 1 instruction/cycle with `if_ready` held high.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `fetch_count` port exists.
  - It is a 32-bit counter that increments on every pop, including a pop in a redirect cycle.
  - It wraps at 2^32 and clears on reset only.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `fetch_pkg`:
  - `XLEN` = 32, `ILEN` = 32.
  - `NOP_INSTR` = 32'h0000_0013.
  - Packed typedef `fetch_entry_t` = {pc[31:0], instr[31:0]}.
  - `PC_STEP` = 4.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t`, parameterised by `DEPTH`.
  - Ports: push, pop, flush, full, empty, head.
  - Pointer wrap by `$clog2(DEPTH)`-bit counters; `count` uses one extra bit.
- `fetch_unit` holds the PC logic, push/redirect arbitration and the optional counter.

## Test plan
- Reset, then `if_ready`=1 with memory words 32'h0062E233, 32'h00B62423, ... at addresses 0, 4, ...:
  - `if_valid` rises in cycle 2.
  - Heads are (0, 32'h0062E233), (4, 32'h00B62423), ... at 1 per cycle.
- Backpressure: `if_ready`=0 for 5 cycles after the first fetch:
  - `count` saturates at 2 and `imem_addr` freezes at 8.
  - On release, PCs 0, 4, 8 are delivered in order with no gap and no duplicate.
- Redirect to 32'h0000_0103 while the FIFO is full:
  - Next cycle `if_valid`=0 and `imem_addr`=32'h0000_0100.
  - The cycle after, head = (32'h100, mem[64]).
- Redirect on consecutive cycles to 0x40 then 0x80: only the 0x80 stream appears. No 0x40 entry is ever valid.
- PC wrap: redirect to 32'hFFFF_FFFC; the next PCs delivered are FFFF_FFFC then 0000_0000.
- With `FETCH_PERF_CNT_EN`: 10 pops, then `rst` for 1 cycle. `fetch_count` reads 10 before the reset and 0 after it.
